m68k_dtack_responder: RTL and testbench
=======================================

// Module: m68k_dtack_responder
// PURPOSE
//  Bus-cycle responder for the 68000 local bus; the target-side counterpart to the address decoder.
//  - Consumes the decoder's chip selects together with AS_L, UDS_L and LDS_L.
//  - ROM, on-chip RAM and IO/DMA: generates DtackOut_L after a per-region wait-state count.
//  - DRAM, graphics and CAN: forwards that peripheral's own DTACK.
//  - Optionally raises BErrOut_L when no acknowledge arrives in time.
// PARAMETERS
//  ROM_WAIT        0    wait states for on-chip ROM cycles
//  RAM_WAIT        1    wait states for on-chip RAM cycles
//  IO_WAIT         2    wait states for IO and DMA cycles
//  CNT_W           8    width of the wait/timeout counter
//  TIMEOUT_CYCLES  255  clocks from cycle start to bus error (requires TIMEOUT_CYCLES < 2**CNT_W)
// PORTS
//  Clk                in   1  system clock, rising edge
//  Reset_L            in   1  asynchronous active-low reset
//  AS_L               in   1  CPU address strobe
//  UDS_L, LDS_L       in   1  CPU upper/lower data strobes
//  OnChipRomSelect_H  in   1  ROM select (decoder)
//  OnChipRamSelect_H  in   1  on-chip RAM select
//  DramSelect_H       in   1  DRAM select
//  IOSelect_H         in   1  IO select
//  DMASelect_L        in   1  DMA controller select, active low
//  GraphicsCS_L       in   1  graphics select, active low
//  CanBusSelect_H     in   1  CAN controller select
//  DramDtack_L        in   1  DTACK from DRAM controller
//  GraphicsDtack_L    in   1  DTACK from graphics controller
//  CanBusDtack_L      in   1  DTACK from CAN controller
//  DtackOut_L         out  1  registered DTACK to CPU
//  BErrOut_L          out  1  registered bus error to CPU
// BEHAVIOUR
//  Reset (asynchronous):
//  - DtackOut_L=1, BErrOut_L=1, state=IDLE, counters cleared.
//  Cycle start:
//  - Defined as the first Clk edge in IDLE where AS_L=0 and (UDS_L=0 or LDS_L=0).
//  - Selects are sampled only at that edge; later select changes are ignored.
//  Select priority:
//  - ROM > RAM > DRAM > IO/DMA > Graphics > CAN.
//  - No select active: state WAIT_EXT with no DTACK source, so the cycle never acks.
//  State machine:
//  - IDLE -> COUNT (ROM/RAM/IO/DMA): load counter with the region's *_WAIT value.
//  - IDLE -> WAIT_EXT (DRAM/Graphics/CAN): record which source to follow.
//  - COUNT: decrement each clock; when counter==0, -> ACK and drive DtackOut_L=0 at that same edge.
//  - WAIT_EXT: the chosen external DTACK is sampled each edge; when sampled low, -> ACK, DtackOut_L=0.
//  - ACK: hold DtackOut_L=0 until AS_L is sampled high, then DtackOut_L=1 and -> IDLE at that edge.
//  Latency:
//  - Internal regions: DtackOut_L falls N+1 edges after cycle start (N = wait count).
//    Example: ROM_WAIT=0 gives DtackOut_L low on the edge after cycle start.
//  - External sources: DtackOut_L falls 1 edge after the source DTACK is first sampled low.
//  Abort and back-to-back:
//  - AS_L sampled high in COUNT or WAIT_EXT: -> IDLE, DtackOut_L stays 1.
//  - Back-to-back cycles: a new cycle start requires AS_L to have been sampled high in between,
//    so no ack is carried over into the next cycle.
//  - External DTACK already low at cycle start: ack still takes 1 edge after cycle start,
//    never 0 edges.
// CONFIGURATION
//  BUS_ERROR_TIMEOUT_EN defined:
//  - A timeout counter clears at cycle start and increments each clock while not in IDLE/ACK.
//  - On reaching TIMEOUT_CYCLES: -> BERR state, BErrOut_L=0, DtackOut_L=1.
//  - BERR holds until AS_L is sampled high, then BErrOut_L=1 and -> IDLE.
//  - DTACK and timeout on the same edge: DTACK wins and no bus error is raised.
//  BUS_ERROR_TIMEOUT_EN undefined:
//  - No timeout counter and no BERR state; BErrOut_L is tied to 1.
//  - An unselected cycle hangs until AS_L goes high.
// TESTING
//  1. ROM cycle, ROM_WAIT=0: AS_L/LDS_L low, OnChipRomSelect_H=1
//     -> DtackOut_L=0 one edge after start; back to 1 one edge after AS_L returns high.
//  2. IO cycle, IO_WAIT=2: -> DtackOut_L=0 exactly 3 edges after start.
//     Variant: AS_L raised after 1 edge -> DtackOut_L never asserts and the block returns to IDLE.
//  3. DRAM cycle, DramDtack_L driven low 5 clocks after start
//     -> DtackOut_L=0 on the next edge; GraphicsDtack_L toggling throughout is ignored.
//  4. ROM and RAM selects both high, RAM_WAIT=1, ROM_WAIT=0 -> ROM wins, ack after 1 edge.
//  5. With BUS_ERROR_TIMEOUT_EN and TIMEOUT_CYCLES=16, no select active
//     -> BErrOut_L=0 at edge 16 after start and DtackOut_L stays 1.
//     Variant: CAN ack arriving on edge 16 -> DtackOut_L=0 and BErrOut_L stays 1.
//  6. Reset_L pulsed low mid-cycle while in ACK -> DtackOut_L=1 immediately (asynchronous);
//     the next valid cycle acks normally.

Source files
------------

// File: rtl/m68k_dtack_responder.sv
// m68k_dtack_responder: target-side DTACK/BERR generator for the 68000 local bus.
// Ports:
//   Clk, Reset_L (async, active low)
//   AS_L, UDS_L, LDS_L                 CPU strobes
//   OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H, IOSelect_H,
//   DMASelect_L, GraphicsCS_L, CanBusSelect_H   decoder selects
//   DramDtack_L, GraphicsDtack_L, CanBusDtack_L peripheral acknowledges
//   DtackOut_L, BErrOut_L               registered acknowledge / bus error to the CPU
// Optional feature: define BUS_ERROR_TIMEOUT_EN to raise BErrOut_L after TIMEOUT_CYCLES.
module m68k_dtack_responder #(
    parameter int ROM_WAIT       = 0,
    parameter int RAM_WAIT       = 1,
    parameter int IO_WAIT        = 2,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clk,
    input  logic Reset_L,
    input  logic AS_L,
    input  logic UDS_L,
    input  logic LDS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic DramSelect_H,
    input  logic IOSelect_H,
    input  logic DMASelect_L,
    input  logic GraphicsCS_L,
    input  logic CanBusSelect_H,
    input  logic DramDtack_L,
    input  logic GraphicsDtack_L,
    input  logic CanBusDtack_L,
    output logic DtackOut_L,
    output logic BErrOut_L
);
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        WAIT_EXT,
`ifdef BUS_ERROR_TIMEOUT_EN
        BERR,
`endif
        ACK
    } state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_DRAM, SRC_GFX, SRC_CAN} src_t;

    state_t           state_q;
    src_t             src_q;
    src_t             src_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] wait_d;
    logic             dtack_q;
    logic             start;
    logic             int_sel;
    logic             ext_dtack_l;
    logic             ack_now;

    assign start   = ~AS_L & (~UDS_L | ~LDS_L);
    // DRAM outranks IO/DMA, so IO/DMA only counts as internal when DRAM is idle
    assign int_sel = OnChipRomSelect_H | OnChipRamSelect_H |
                     (~DramSelect_H & (IOSelect_H | ~DMASelect_L));
    assign wait_d  = OnChipRomSelect_H ? CNT_W'(ROM_WAIT) :
                     OnChipRamSelect_H ? CNT_W'(RAM_WAIT) : CNT_W'(IO_WAIT);
    assign src_d   = DramSelect_H    ? SRC_DRAM :
                     ~GraphicsCS_L   ? SRC_GFX  :
                     CanBusSelect_H  ? SRC_CAN  : SRC_NONE;
    assign ext_dtack_l = src_q == SRC_DRAM ? DramDtack_L     :
                         src_q == SRC_GFX  ? GraphicsDtack_L :
                         src_q == SRC_CAN  ? CanBusDtack_L   : 1'b1;
    assign ack_now = state_q == COUNT ? cnt_q == '0 : ~ext_dtack_l;
    assign DtackOut_L = dtack_q;

`ifdef BUS_ERROR_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_q;
    logic             berr_q;
    logic             tmo_hit;

    assign tmo_hit   = (tmo_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES);
    assign BErrOut_L = berr_q;
`else
    assign BErrOut_L = 1'b1;
`endif

    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q <= IDLE;
            src_q   <= SRC_NONE;
            cnt_q   <= '0;
            dtack_q <= 1'b1;
`ifdef BUS_ERROR_TIMEOUT_EN
            tmo_q   <= '0;
            berr_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: if (start) begin
`ifdef BUS_ERROR_TIMEOUT_EN
                    tmo_q <= '0;
`endif
                    if (int_sel) begin
                        state_q <= COUNT;
                        cnt_q   <= wait_d;
                    end else begin
                        state_q <= WAIT_EXT;
                        src_q   <= src_d;
                    end
                end
                COUNT, WAIT_EXT: begin
`ifdef BUS_ERROR_TIMEOUT_EN
                    tmo_q <= tmo_q + CNT_W'(1);
`endif
                    // abort beats ack, and ack beats a simultaneous timeout
                    if (AS_L) begin
                        state_q <= IDLE;
                    end else if (ack_now) begin
                        state_q <= ACK;
                        dtack_q <= 1'b0;
`ifdef BUS_ERROR_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        state_q <= BERR;
                        berr_q  <= 1'b0;
`endif
                    end else if (state_q == COUNT) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ACK: if (AS_L) begin
                    state_q <= IDLE;
                    dtack_q <= 1'b1;
                end
`ifdef BUS_ERROR_TIMEOUT_EN
                BERR: if (AS_L) begin
                    state_q <= IDLE;
                    berr_q  <= 1'b1;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_m68k_dtack_responder.sv
// tb_m68k_dtack_responder: directed checks of wait states, forwarding, priority, abort, timeout and reset.
module tb_m68k_dtack_responder;
    logic clk = 1'b0;
    logic rst_l;
    logic as_l, uds_l, lds_l;
    logic rom_sel, ram_sel, dram_sel, io_sel, dma_sel_l, gfx_cs_l, can_sel;
    logic dram_dtack_l, gfx_dtack_l, can_dtack_l;
    logic dtack_l, berr_l;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    m68k_dtack_responder #(
        .ROM_WAIT(0), .RAM_WAIT(1), .IO_WAIT(2), .CNT_W(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .Clk(clk), .Reset_L(rst_l), .AS_L(as_l), .UDS_L(uds_l), .LDS_L(lds_l),
        .OnChipRomSelect_H(rom_sel), .OnChipRamSelect_H(ram_sel),
        .DramSelect_H(dram_sel), .IOSelect_H(io_sel), .DMASelect_L(dma_sel_l),
        .GraphicsCS_L(gfx_cs_l), .CanBusSelect_H(can_sel),
        .DramDtack_L(dram_dtack_l), .GraphicsDtack_L(gfx_dtack_l), .CanBusDtack_L(can_dtack_l),
        .DtackOut_L(dtack_l), .BErrOut_L(berr_l)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        as_l = 1'b1; uds_l = 1'b1; lds_l = 1'b1;
        rom_sel = 1'b0; ram_sel = 1'b0; dram_sel = 1'b0; io_sel = 1'b0;
        dma_sel_l = 1'b1; gfx_cs_l = 1'b1; can_sel = 1'b0;
        dram_dtack_l = 1'b1; gfx_dtack_l = 1'b1; can_dtack_l = 1'b1;
    endtask

    // ends the current cycle and leaves the block in IDLE
    task automatic end_cycle(input string tag);
        idle_bus();
        tick();
        check({tag, "_release"}, dtack_l, 1'b1);
        tick();
    endtask

    initial begin
        idle_bus();
        rst_l = 1'b0;
        tick(); tick();
        check("reset_dtack", dtack_l, 1'b1);
        check("reset_berr", berr_l, 1'b1);
        rst_l = 1'b1;
        tick();

        // ROM, zero wait states; select dropped mid-cycle is ignored
        rom_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick(); check("rom_e0", dtack_l, 1'b1);
        rom_sel = 1'b0;
        tick(); check("rom_e1", dtack_l, 1'b0);
        tick(); check("rom_hold", dtack_l, 1'b0);
        end_cycle("rom");

        // IO, two wait states
        io_sel = 1'b1; as_l = 1'b0; uds_l = 1'b0;
        tick();
        tick(); check("io_e1", dtack_l, 1'b1);
        tick(); check("io_e2", dtack_l, 1'b1);
        tick(); check("io_e3", dtack_l, 1'b0);
        end_cycle("io");

        // IO aborted after one edge, then a ROM cycle proves we are back in IDLE
        io_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick();
        idle_bus();
        for (int i = 0; i < 4; i++) begin
            tick(); check("io_abort", dtack_l, 1'b1);
        end
        rom_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick(); tick(); check("after_abort_rom", dtack_l, 1'b0);
        end_cycle("after_abort");

        // DRAM forwarded; graphics DTACK toggles but is unselected
        dram_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            gfx_dtack_l = ~gfx_dtack_l;
            tick(); check("dram_wait", dtack_l, 1'b1);
        end
        dram_dtack_l = 1'b0;
        tick(); check("dram_ack", dtack_l, 1'b0);
        end_cycle("dram");

        // ROM beats RAM
        rom_sel = 1'b1; ram_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick();
        tick(); check("rom_over_ram", dtack_l, 1'b0);
        end_cycle("rom_ram");

        // RAM alone, one wait state
        ram_sel = 1'b1; as_l = 1'b0; uds_l = 1'b0;
        tick();
        tick(); check("ram_e1", dtack_l, 1'b1);
        tick(); check("ram_e2", dtack_l, 1'b0);
        end_cycle("ram");

        // DRAM beats IO: IO timing would ack on edge 3, DRAM dtack never comes
        dram_sel = 1'b1; io_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick(); tick(); tick();
        tick(); check("dram_over_io", dtack_l, 1'b1);
        end_cycle("dram_io");

        // DMA select is active low and uses the IO wait count
        dma_sel_l = 1'b0; as_l = 1'b0; lds_l = 1'b0;
        tick(); tick();
        tick(); check("dma_e2", dtack_l, 1'b1);
        tick(); check("dma_e3", dtack_l, 1'b0);
        end_cycle("dma");

        // CAN with DTACK already low at start: still one edge of latency
        can_sel = 1'b1; can_dtack_l = 1'b0; as_l = 1'b0; lds_l = 1'b0;
        tick(); check("can_pre_e0", dtack_l, 1'b1);
        tick(); check("can_pre_e1", dtack_l, 1'b0);
        end_cycle("can_pre");

        // graphics selected, forwarded
        gfx_cs_l = 1'b0; as_l = 1'b0; uds_l = 1'b0;
        tick(); tick(); check("gfx_wait", dtack_l, 1'b1);
        gfx_dtack_l = 1'b0;
        tick(); check("gfx_ack", dtack_l, 1'b0);
        end_cycle("gfx");

        // strobes without a data strobe do not start a cycle
        rom_sel = 1'b1; as_l = 1'b0;
        tick(); tick(); check("no_ds", dtack_l, 1'b1);
        end_cycle("no_ds");

`ifdef BUS_ERROR_TIMEOUT_EN
        // no select: bus error on edge 16
        as_l = 1'b0; lds_l = 1'b0;
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick(); check("tmo_wait", berr_l, 1'b1);
        end
        tick();
        check("tmo_berr", berr_l, 1'b0);
        check("tmo_dtack", dtack_l, 1'b1);
        tick(); check("tmo_hold", berr_l, 1'b0);
        idle_bus();
        tick(); check("tmo_release", berr_l, 1'b1);
        tick();

        // CAN ack on edge 16 wins over the timeout
        can_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick();
        for (int i = 1; i <= 15; i++) tick();
        can_dtack_l = 1'b0;
        tick();
        check("tmo_can_dtack", dtack_l, 1'b0);
        check("tmo_can_berr", berr_l, 1'b1);
        end_cycle("tmo_can");
`else
        // no select: hangs with no ack and no bus error
        as_l = 1'b0; lds_l = 1'b0;
        tick();
        for (int i = 1; i <= 20; i++) tick();
        check("hang_dtack", dtack_l, 1'b1);
        check("hang_berr", berr_l, 1'b1);
        end_cycle("hang");
`endif

        // asynchronous reset while in ACK
        rom_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick(); tick(); check("pre_reset_ack", dtack_l, 1'b0);
        rst_l = 1'b0;
        #2; check("async_reset", dtack_l, 1'b1);
        idle_bus();
        rst_l = 1'b1;
        tick(); tick();
        rom_sel = 1'b1; as_l = 1'b0; lds_l = 1'b0;
        tick(); check("post_reset_e0", dtack_l, 1'b1);
        tick(); check("post_reset_e1", dtack_l, 1'b0);
        end_cycle("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
